// File: rtl/lsu_pkg.sv
// lsu_pkg: size codes, FSM states and byte-lane masks shared by the load/store unit
package lsu_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSV  = 2'b11;
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;
    localparam logic [3:0] LANE_B  = 4'b0001;
    localparam logic [3:0] LANE_H0 = 4'b0011;
    localparam logic [3:0] LANE_H1 = 4'b1100;
    localparam logic [3:0] LANE_W  = 4'b1111;
endpackage

// File: rtl/load_extend.sv
// load_extend: picks the addressed byte/half of a read word and sign- or zero-extends it
// rdata: memory word, off: byte offset, size: access size, sgn: sign-extend, data: 32b result
module load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        sgn,
    output logic [31:0] data
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        b = rdata[{off, 3'b000} +: 8];
        h = off[1] ? rdata[31:16] : rdata[15:0];
        data = size == SZ_BYTE ? {{24{sgn & b[7]}}, b} :
               size == SZ_HALF ? {{16{sgn & h[15]}}, h} : rdata;
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store initiator towards data_memory
// req_*: request handshake from EX; resp_*: load result / store completion with error flag
// mem_*: word address, lane-replicated write data, byte enables, read word
// LSU_ALIGN_CHECK_EN: when defined, misaligned half/word accesses error instead of being forced aligned
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wren,
    input  logic [31:0]       mem_rdata
);
    localparam logic [1:0] LAT_INIT = 2'(MEM_LATENCY - 1);
    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d, size_q, size_d, off_q, off_d;
    logic              we_q, we_d, sgn_q, sgn_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d, resp_rdata_q, resp_rdata_d;
    logic [3:0]        mem_wren_q, mem_wren_d;
    logic              resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
    logic              acc, err, done, hs;
    logic [1:0]        off;
    logic [3:0]        wren;
    logic [31:0]       wdata, ld_data;

    load_extend u_ext (
        .rdata (mem_rdata),
        .off   (off_q),
        .size  (size_q),
        .sgn   (sgn_q),
        .data  (ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 2'd0;
            size_q       <= 2'd0;
            off_q        <= 2'd0;
            we_q         <= 1'b0;
            sgn_q        <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'd0;
            mem_wren_q   <= 4'd0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            size_q       <= size_d;
            off_q        <= off_d;
            we_q         <= we_d;
            sgn_q        <= sgn_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wren_q   <= mem_wren_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:           state_d = acc ? (err ? ST_RESP : ST_ISSUE) : ST_IDLE;
            ST_ISSUE, ST_WAIT: state_d = done ? ST_RESP : ST_WAIT;
            ST_RESP:           state_d = resp_ready ? ST_IDLE : ST_RESP;
            default:           state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        acc = req_valid && state_q == ST_IDLE;
`ifdef LSU_ALIGN_CHECK_EN
        err = req_size == SZ_RSV || (req_size == SZ_HALF && req_addr[0]) ||
              (req_size == SZ_WORD && req_addr[1:0] != 2'b00);
        off = req_addr[1:0];
`else
        err = req_size == SZ_RSV;
        // misaligned low bits are dropped: half keeps addr[1], word uses lane 0
        off = req_size == SZ_WORD ? 2'b00 : req_size == SZ_HALF ? {req_addr[1], 1'b0} : req_addr[1:0];
`endif
        wren  = req_size == SZ_BYTE ? LANE_B << off : req_size == SZ_HALF ? (off[1] ? LANE_H1 : LANE_H0) : LANE_W;
        wdata = req_size == SZ_BYTE ? {4{req_wdata[7:0]}} : req_size == SZ_HALF ? {2{req_wdata[15:0]}} : req_wdata;
        // stores finish after the single ISSUE cycle; loads when the latency count hits 0
        done  = (state_q == ST_ISSUE || state_q == ST_WAIT) && (we_q || cnt_q == 2'd0);
        hs    = state_q == ST_RESP && resp_ready;
        cnt_d        = acc ? LAT_INIT : cnt_q != 2'd0 ? cnt_q - 2'd1 : cnt_q;
        size_d       = acc ? req_size : size_q;
        off_d        = acc ? off : off_q;
        we_d         = acc ? req_we : we_q;
        sgn_d        = acc ? req_signed : sgn_q;
        mem_addr_d   = acc && !err ? {req_addr[ADDR_W-1:2], 2'b00} : mem_addr_q;
        mem_wdata_d  = acc && !err && req_we ? wdata : mem_wdata_q;
        mem_wren_d   = acc && !err && req_we ? wren : 4'b0000;
        resp_valid_d = (acc && err) || done ? 1'b1 : hs ? 1'b0 : resp_valid_q;
        resp_err_d   = acc && err ? 1'b1 : hs ? 1'b0 : resp_err_q;
        resp_rdata_d = done && !we_q ? ld_data : hs ? 32'd0 : resp_rdata_q;
    end

    always_comb begin
        req_ready  = state_q == ST_IDLE;
        mem_addr   = mem_addr_q;
        mem_wdata  = mem_wdata_q;
        mem_wren   = mem_wren_q;
        resp_valid = resp_valid_q;
        resp_rdata = resp_rdata_q;
        resp_err   = resp_err_q;
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of load_store_unit against a latency-3 memory model
module tb_load_store_unit;
    localparam int LAT = 3;
`ifdef LSU_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0, resp_ready = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wren;
    logic [31:0] mem [0:1023];
    logic [31:0] p1, p2, saved;
    int          passed = 0, total = 0;

    load_store_unit #(.ADDR_W(32), .MEM_LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (mem_wren[i]) mem[mem_addr[11:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
        p1 <= mem[mem_addr[11:2]];
        p2 <= p1;
    end
    assign mem_rdata = p2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic access(input string tag, input logic we, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] d, input logic [3:0] ew,
                          input logic [31:0] ewd, input logic [31:0] er, input logic ee);
        int   n;
        logic extra;
        int   el;
        el = ee ? 1 : we ? 2 : LAT + 1;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = d;
        chk({tag, ".ready"}, req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk({tag, ".wren"}, mem_wren, ew);
        if (!ee) chk({tag, ".addr"}, mem_addr, {a[31:2], 2'b00});
        if (we && !ee) chk({tag, ".wdata"}, mem_wdata, ewd);
        n = 1;
        extra = 1'b0;
        while (!resp_valid && n < 16) begin
            @(negedge clk);
            extra |= |mem_wren;
            n++;
        end
        chk({tag, ".lat"}, n, el);
        chk({tag, ".extra_wren"}, extra, 0);
        chk({tag, ".err"}, resp_err, ee);
        chk({tag, ".rdata"}, resp_rdata, er);
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        chk({tag, ".clr"}, resp_valid, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst.ready", req_ready, 1);
        chk("rst.valid", resp_valid, 0);
        chk("rst.wren", mem_wren, 0);
        chk("rst.addr", mem_addr, 0);
        chk("rst.wdata", mem_wdata, 0);
        chk("rst.rdata", resp_rdata, 0);
        chk("rst.err", resp_err, 0);

        access("st_w", 1, 2'b10, 0, 32'h0003_FFF0, 32'd125, 4'b1111, 32'd125, 0, 0);
        access("ld_w", 0, 2'b10, 0, 32'h0003_FFF0, 0, 4'b0000, 0, 32'h0000_007D, 0);
        access("st_w2", 1, 2'b10, 0, 32'h0003_FFE8, 32'h1122_3344, 4'b1111, 32'h1122_3344, 0, 0);
        access("st_b", 1, 2'b00, 0, 32'h0003_FFE9, 32'h1234_56A5, 4'b0010, 32'hA5A5_A5A5, 0, 0);
        access("ld_bs", 0, 2'b00, 1, 32'h0003_FFE9, 0, 4'b0000, 0, 32'hFFFF_FFA5, 0);
        access("ld_bu", 0, 2'b00, 0, 32'h0003_FFE9, 0, 4'b0000, 0, 32'h0000_00A5, 0);
        access("ld_b3", 0, 2'b00, 1, 32'h0003_FFEB, 0, 4'b0000, 0, 32'h0000_0011, 0);
        access("st_h", 1, 2'b01, 0, 32'h0003_FFE2, 32'hDEAD_8001, 4'b1100, 32'h8001_8001, 0, 0);
        access("ld_hs", 0, 2'b01, 1, 32'h0003_FFE2, 0, 4'b0000, 0, 32'hFFFF_8001, 0);
        access("ld_hu", 0, 2'b01, 0, 32'h0003_FFE2, 0, 4'b0000, 0, 32'h0000_8001, 0);
        access("ld_h0", 0, 2'b01, 0, 32'h0003_FFE8, 0, 4'b0000, 0, 32'h0000_A544, 0);
        if (ALIGN) begin
            access("ld_hmis", 0, 2'b01, 0, 32'h0003_FFEB, 0, 4'b0000, 0, 0, 1);
            access("ld_wmis", 0, 2'b10, 0, 32'h0003_FFEA, 0, 4'b0000, 0, 0, 1);
            access("st_hmis", 1, 2'b01, 0, 32'h0003_FFE3, 32'h0000_BEEF, 4'b0000, 0, 0, 1);
        end else begin
            access("ld_hmis", 0, 2'b01, 0, 32'h0003_FFEB, 0, 4'b0000, 0, 32'h0000_1122, 0);
            access("ld_wmis", 0, 2'b10, 0, 32'h0003_FFEA, 0, 4'b0000, 0, 32'h1122_A544, 0);
            access("st_hmis", 1, 2'b01, 0, 32'h0003_FFE3, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF, 0, 0);
        end
        access("st_rsv", 1, 2'b11, 0, 32'h0003_FFF0, 32'hFFFF_FFFF, 4'b0000, 0, 0, 1);
        access("ld_rsv", 0, 2'b11, 0, 32'h0003_FFF0, 0, 4'b0000, 0, 0, 1);
        access("st_top", 1, 2'b10, 0, 32'hFFFF_FFFC, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 0, 0);
        access("ld_top", 0, 2'b10, 0, 32'hFFFF_FFFC, 0, 4'b0000, 0, 32'hCAFE_F00D, 0);

        // response held off while a second request waits
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h0003_FFF0;
        @(posedge clk);
        @(negedge clk);
        req_we = 1'b1; req_wdata = 32'd0;
        for (int n = 0; n < 16 && !resp_valid; n++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("hold.valid", resp_valid, 1);
            chk("hold.rdata", resp_rdata, 32'h0000_007D);
            chk("hold.err", resp_err, 0);
            chk("hold.ready", req_ready, 0);
            chk("hold.wren", mem_wren, 0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        chk("hold.clr", resp_valid, 0);
        chk("hold.mem", mem[10'h3FC], 32'd125);

        // reset during the ISSUE cycle of a store
        saved = mem[10'h040];
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h0000_0100; req_wdata = 32'h1234_5678;
        @(posedge clk);
        #1 rst_n = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("arst.wren", mem_wren, 0);
        chk("arst.addr", mem_addr, 0);
        chk("arst.valid", resp_valid, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("arst.novalid", resp_valid, 0);
        end
        chk("arst.mem", mem[10'h040], saved);
        access("ld_after", 0, 2'b10, 0, 32'h0003_FFF0, 0, 4'b0000, 0, 32'h0000_007D, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
